// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-side bundle for the write arbiter.
// slave = arbiter side, master = environment side.
interface fifo_write_arbiter_if;
   logic        en;
   logic [3:0]  req;
   logic [31:0] din;
   logic [3:0]  gnt;
   logic        fifo_write;
   logic [7:0]  fifo_data;
   logic        fifo_read;
   logic        fifo_ready;
   logic [2:0]  count;
   logic        full;

   modport slave (
      input  en, req, din, fifo_read, fifo_ready,
      output gnt, fifo_write, fifo_data, count, full
   );

   modport master (
      output en, req, din, fifo_read, fifo_ready,
      input  gnt, fifo_write, fifo_data, count, full
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one byte FIFO among 4 producers.
// A shadow occupancy count keeps every issued write droppable-free.
module fifo_write_arbiter #(
   parameter int NREQ = 4,
   parameter int CAP  = 7
) (
   input logic                 clk,
   input logic                 clrn,
   fifo_write_arbiter_if.slave bus
);

   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] elig;
   logic            wr_q, wr_d;
   logic [7:0]      data_q, data_d;
   logic [2:0]      count_q, count_d;
   logic [1:0]      last_q, last_d;
   logic [1:0]      win, idx;
   logic            found, rd, issue;
   logic [3:0]      occ;

   always_comb begin
      elig  = bus.req & ~gnt_q;
      occ   = {1'b0, count_q} + {3'b000, wr_q};
      rd    = bus.fifo_read & bus.fifo_ready;
      win   = last_q;
      idx   = '0;
      found = 1'b0;
      // search starts just after the last winner
      for (int k = 1; k <= NREQ; k++) begin
         idx = last_q + 2'(k);
         if (!found && elig[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      issue  = bus.en & found & (occ < 4'(CAP));
      gnt_d  = '0;
      wr_d   = issue;
      data_d = data_q;
      last_d = last_q;
      if (issue) begin
         gnt_d[win] = 1'b1;
         data_d     = bus.din[{win, 3'b000} +: 8];
         last_d     = win;
      end
      count_d = count_q + {2'b00, wr_q} - {2'b00, rd};
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         gnt_q   <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
         count_q <= '0;
         last_q  <= 2'd3;
      end else begin
         gnt_q   <= gnt_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.fifo_write = wr_q;
   assign bus.fifo_data  = data_q;
   assign bus.count      = count_q;
   assign bus.full       = (occ >= 4'(CAP));

endmodule
